// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports, two posedge write ports
// (pipeline and late writeback) and a per-register busy scoreboard.
module regfile_mp #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned NRD     = 2,
   parameter int unsigned ZERO_R0 = 1,
   parameter int unsigned BYPASS  = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NRD*ADDR_W-1:0]    rd_addr,
   output logic [NRD*DATA_W-1:0]    rd_data,
   output logic [NRD-1:0]           rd_busy,
   input  logic                     we0,
   input  logic [ADDR_W-1:0]        wa0,
   input  logic [DATA_W-1:0]        wd0,
   input  logic                     we1,
   input  logic [ADDR_W-1:0]        wa1,
   input  logic [DATA_W-1:0]        wd1,
   input  logic                     claim_en,
   input  logic [ADDR_W-1:0]        claim_addr,
   output logic                     busy_any
);

   localparam int unsigned DEPTH = 2**ADDR_W;
   localparam bit          ZR    = (ZERO_R0 != 0);
   localparam bit          BP    = (BYPASS != 0);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  busy;

   logic wr0_ok, wr1_ok, clm_ok, byp_ok;

   assign wr0_ok = we0 && !(ZR && (wa0 == '0));
   assign wr1_ok = we1 && !(ZR && (wa1 == '0));
   assign clm_ok = claim_en && !(ZR && (claim_addr == '0));
   // Bypass is suppressed in reset so reads show the cleared state
   assign byp_ok = BP && rst_n;

   // Storage: WB1 has priority over WB0 on an address collision
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (wr0_ok && !(wr1_ok && (wa1 == wa0))) begin
            mem[wa0] <= wd0;
         end
         if (wr1_ok) begin
            mem[wa1] <= wd1;
         end
      end
   end

   // Scoreboard: claim is applied after release so a same-cycle claim wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         if (wr1_ok) begin
            busy[wa1] <= 1'b0;
         end
         if (clm_ok) begin
            busy[claim_addr] <= 1'b1;
         end
      end
   end

   assign busy_any = |busy;

   for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              is_zero;
      logic [DATA_W-1:0] data;
      logic              bsy;

      assign addr    = rd_addr[k*ADDR_W +: ADDR_W];
      assign is_zero = ZR && (addr == '0);

      always_comb begin
         data = mem[addr];
         if (byp_ok && we0 && (wa0 == addr)) data = wd0;
         if (byp_ok && we1 && (wa1 == addr)) data = wd1;
         if (is_zero) data = '0;
      end

      always_comb begin
         bsy = busy[addr];
         if (byp_ok && we1 && (wa1 == addr) && !(claim_en && (claim_addr == addr))) bsy = 1'b0;
         if (is_zero) bsy = 1'b0;
      end

      assign rd_data[k*DATA_W +: DATA_W] = data;
      assign rd_busy[k]                  = bsy;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default config, a no-bypass/no-zero-r0 config
// sharing the same stimulus, and a 4-port 16-bit config for lane independence.
module tb_regfile_mp;

   logic        clk;
   logic        rst_n;

   // Shared stimulus for u_a (BYPASS=1, ZERO_R0=1) and u_b (BYPASS=0, ZERO_R0=0)
   logic [9:0]  rd_addr;
   logic        we0, we1, claim_en;
   logic [4:0]  wa0, wa1, claim_addr;
   logic [31:0] wd0, wd1;
   logic [63:0] rd_data_a, rd_data_b;
   logic [1:0]  rd_busy_a, rd_busy_b;
   logic        busy_any_a, busy_any_b;

   // Stimulus for u_c (NRD=4, DATA_W=16, ADDR_W=3)
   logic [11:0] rd_addr_c;
   logic        we0_c, we1_c, claim_en_c;
   logic [2:0]  wa0_c, wa1_c, claim_addr_c;
   logic [15:0] wd0_c, wd1_c;
   logic [63:0] rd_data_c;
   logic [3:0]  rd_busy_c;
   logic        busy_any_c;

   int checks;
   int passes;

   regfile_mp u_a (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
      .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
      .claim_en(claim_en), .claim_addr(claim_addr), .busy_any(busy_any_a)
   );

   regfile_mp #(.ZERO_R0(0), .BYPASS(0)) u_b (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
      .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
      .claim_en(claim_en), .claim_addr(claim_addr), .busy_any(busy_any_b)
   );

   regfile_mp #(.DATA_W(16), .ADDR_W(3), .NRD(4)) u_c (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr_c), .rd_data(rd_data_c), .rd_busy(rd_busy_c),
      .we0(we0_c), .wa0(wa0_c), .wd0(wd0_c), .we1(we1_c), .wa1(wa1_c), .wd1(wd1_c),
      .claim_en(claim_en_c), .claim_addr(claim_addr_c), .busy_any(busy_any_c)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we0 = 1'b0; we1 = 1'b0; claim_en = 1'b0;
      wa0 = '0; wa1 = '0; claim_addr = '0; wd0 = '0; wd1 = '0;
   endtask

   task automatic set_rd(input logic [4:0] p0, input logic [4:0] p1);
      rd_addr = {p1, p0};
   endtask

   initial begin
      checks = 0;
      passes = 0;
      rst_n  = 1'b0;
      idle();
      set_rd(5'd3, 5'd3);
      rd_addr_c = '0; we0_c = 1'b0; we1_c = 1'b0; claim_en_c = 1'b0;
      wa0_c = '0; wa1_c = '0; claim_addr_c = '0; wd0_c = '0; wd1_c = '0;

      // Writes and claims while in reset are ignored, and no bypass shows through
      we1 = 1'b1; wa1 = 5'd3; wd1 = 32'hFFFF_FFFF; claim_en = 1'b1; claim_addr = 5'd3;
      #2;
      chk("rst_bypass_a", rd_data_a, 64'h0);
      tick();
      tick();
      chk("rst_data_a", rd_data_a, 64'h0);
      chk("rst_busy_a", {62'h0, rd_busy_a}, 64'h0);
      chk("rst_busy_any_a", {63'h0, busy_any_a}, 64'h0);
      chk("rst_data_b", rd_data_b, 64'h0);
      idle();
      rst_n = 1'b1;

      // Reset mid-run
      we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hDEAD_BEEF; claim_en = 1'b1; claim_addr = 5'd5;
      tick();
      idle();
      set_rd(5'd3, 5'd5);
      #1;
      chk("mid_pre_data_a", {32'h0, rd_data_a[31:0]}, 64'hDEAD_BEEF);
      chk("mid_pre_busy_a", {63'h0, rd_busy_a[1]}, 64'h1);
      chk("mid_pre_data_b", {32'h0, rd_data_b[31:0]}, 64'hDEAD_BEEF);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_data_a", {32'h0, rd_data_a[31:0]}, 64'h0);
      chk("mid_rst_busy_a", {63'h0, rd_busy_a[1]}, 64'h0);
      chk("mid_rst_busy_any_a", {63'h0, busy_any_a}, 64'h0);
      chk("mid_rst_data_b", {32'h0, rd_data_b[31:0]}, 64'h0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("mid_post_data_a", {32'h0, rd_data_a[31:0]}, 64'h0);
      chk("mid_post_busy_a", {63'h0, rd_busy_a[1]}, 64'h0);
      chk("mid_post_busy_b", {63'h0, rd_busy_b[1]}, 64'h0);

      // Bypass: reg7 holds 0x22, then a same-cycle write of 0x11
      set_rd(5'd7, 5'd0);
      we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h22;
      tick();
      wd0 = 32'h11;
      #1;
      chk("byp_same_a", {32'h0, rd_data_a[31:0]}, 64'h11);
      chk("byp_same_b", {32'h0, rd_data_b[31:0]}, 64'h22);
      tick();
      idle();
      #1;
      chk("byp_next_a", {32'h0, rd_data_a[31:0]}, 64'h11);
      chk("byp_next_b", {32'h0, rd_data_b[31:0]}, 64'h11);

      // Collision on reg9: WB1 wins
      set_rd(5'd9, 5'd9);
      we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hA;
      we1 = 1'b1; wa1 = 5'd9; wd1 = 32'hB;
      #1;
      chk("coll_same_a", rd_data_a, {32'hB, 32'hB});
      chk("coll_same_b", rd_data_b, 64'h0);
      tick();
      idle();
      #1;
      chk("coll_next_a", {32'h0, rd_data_a[31:0]}, 64'hB);
      chk("coll_next_b", {32'h0, rd_data_b[31:0]}, 64'hB);

      // Scoreboard on reg12
      set_rd(5'd12, 5'd12);
      claim_en = 1'b1; claim_addr = 5'd12;
      #1;
      chk("claim_same_a", {62'h0, rd_busy_a}, 64'h0);
      tick();
      idle();
      #1;
      chk("claim_next_a", {62'h0, rd_busy_a}, 64'h3);
      chk("claim_any_a", {63'h0, busy_any_a}, 64'h1);
      chk("claim_next_b", {62'h0, rd_busy_b}, 64'h3);
      we1 = 1'b1; wa1 = 5'd12; wd1 = 32'h55;
      #1;
      chk("rel_busy_a", {62'h0, rd_busy_a}, 64'h0);
      chk("rel_data_a", {32'h0, rd_data_a[31:0]}, 64'h55);
      chk("rel_any_a", {63'h0, busy_any_a}, 64'h1);
      chk("rel_busy_b", {62'h0, rd_busy_b}, 64'h3);
      chk("rel_data_b", {32'h0, rd_data_b[31:0]}, 64'h0);
      tick();
      idle();
      #1;
      chk("rel_next_any_a", {63'h0, busy_any_a}, 64'h0);
      chk("rel_next_any_b", {63'h0, busy_any_b}, 64'h0);
      chk("rel_next_data_b", {32'h0, rd_data_b[31:0]}, 64'h55);
      claim_en = 1'b1; claim_addr = 5'd12;
      we1 = 1'b1; wa1 = 5'd12; wd1 = 32'h66;
      #1;
      chk("clmrel_same_busy_a", {63'h0, rd_busy_a[0]}, 64'h0);
      chk("clmrel_same_data_a", {32'h0, rd_data_a[31:0]}, 64'h66);
      tick();
      idle();
      #1;
      chk("clmrel_next_busy_a", {63'h0, rd_busy_a[0]}, 64'h1);
      chk("clmrel_next_busy_b", {63'h0, rd_busy_b[0]}, 64'h1);
      we1 = 1'b1; wa1 = 5'd12; wd1 = 32'h77;
      tick();
      idle();
      #1;
      chk("clean_any_a", {63'h0, busy_any_a}, 64'h0);

      // Zero register
      set_rd(5'd0, 5'd0);
      we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF;
      we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF;
      claim_en = 1'b1; claim_addr = 5'd0;
      #1;
      chk("zero_same_data_a", rd_data_a, 64'h0);
      chk("zero_same_busy_a", {62'h0, rd_busy_a}, 64'h0);
      tick();
      idle();
      #1;
      chk("zero_next_data_a", rd_data_a, 64'h0);
      chk("zero_next_busy_a", {62'h0, rd_busy_a}, 64'h0);
      chk("zero_next_any_a", {63'h0, busy_any_a}, 64'h0);
      chk("zero_next_data_b", rd_data_b, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("zero_next_busy_b", {62'h0, rd_busy_b}, 64'h3);

      // Port independence on the 4-port instance
      for (int i = 1; i < 8; i++) begin
         we0_c = 1'b1; wa0_c = 3'(i); wd0_c = 16'(i * 16'h111);
         tick();
      end
      we0_c = 1'b0;
      for (int c = 0; c < 4; c++) begin
         logic [2:0] a;
         for (int k = 0; k < 4; k++) begin
            a = 3'((k + 2 * c) % 8);
            rd_addr_c[k*3 +: 3] = a;
         end
         #1;
         for (int k = 0; k < 4; k++) begin
            logic [15:0] exp16;
            a = 3'((k + 2 * c) % 8);
            exp16 = (a == 3'd0) ? 16'h0 : 16'(int'(a) * 16'h111);
            chk($sformatf("lane_c%0d_k%0d", c, k), {48'h0, rd_data_c[k*16 +: 16]}, {48'h0, exp16});
         end
         chk($sformatf("lane_busy_c%0d", c), {60'h0, rd_busy_c}, 64'h0);
         tick();
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file that succeeds the single-write, two-read 32×32 regfile. It provides NRD combinational read ports and two posedge write ports: WB0 for in-order pipeline writeback and WB1 for late/load writeback. Optional same-cycle write-to-read bypass and a per-register busy scoreboard (claim/release) let the decode stage detect pending late results. It sits between decode (read, claim) and the two writeback paths.

## Interface

- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NRD, 2, number of read ports (1..4)
- ZERO_R0, 1, 1 = register 0 reads 0; writes and claims to it are ignored
- BYPASS, 1, 1 = reads return same-cycle write data and same-cycle busy release

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low; clk and asynchronous active-low rst_n only, one clock domain
- rd_addr  in  NRD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W]
- rd_busy  out  NRD  1 = register on port k has an outstanding claim
- we0, wa0, wd0  in  1/ADDR_W/DATA_W  write port 0 (pipeline writeback)
- we1, wa1, wd1  in  1/ADDR_W/DATA_W  write port 1 (late writeback; also releases busy)
- claim_en, claim_addr  in  1/ADDR_W  mark a register busy (a late result is pending)
- busy_any  out  1  OR of all busy bits

## Operation

- Storage: DEPTH×DATA_W array plus a DEPTH-bit busy vector.
- rst_n low (asynchronous, at any time, including mid-operation): all registers = 0, all busy = 0. Therefore rd_data = 0, rd_busy = 0 and busy_any = 0 while in reset. Writes and claims are ignored while rst_n is low.
- Write: on posedge, if weN and not (ZERO_R0 and waN == 0), then reg[waN] <= wdN.
- Write collision (we0 and we1, wa0 == wa1): WB1 wins. The WB0 data is dropped.
- Busy set: on posedge, if claim_en and not (ZERO_R0 and claim_addr == 0), then busy[claim_addr] <= 1.
- Busy clear: on posedge, if we1 (valid address), then busy[wa1] <= 0. WB0 never touches busy.
- Claim and release of the same address in the same cycle: claim wins, so the bit stays 1 (a new owner).
- Read data, port k:
  - if ZERO_R0 and addr == 0: 0;
  - else if BYPASS and we1 and wa1 == addr: wd1;
  - else if BYPASS and we0 and wa0 == addr: wd0;
  - else reg[addr].
- Read busy, port k:
  - if ZERO_R0 and addr == 0: 0;
  - else if BYPASS and we1 and wa1 == addr and not (claim_en and claim_addr == addr): 0;
  - else busy[addr].
  - A same-cycle claim does not appear on rd_busy until the next cycle.
- BYPASS = 0: reads and busy show registered state only.
- Address is always < DEPTH, so there is no wrap case. Widths are exact and there is no arithmetic.

## Timing

- Write latency: 1 posedge to the array. With BYPASS=1 the data is visible combinationally in the same cycle.
- Claim latency: busy is visible from the cycle after claim_en.
- Release: with BYPASS=1 the bit reads 0 in the release cycle; with BYPASS=0 it reads 0 the cycle after.
- rd_data, rd_busy and busy_any are combinational from state and inputs. There are no stalls and no handshake; every cycle accepts 2 writes, 1 claim and NRD reads.
- rst_n deassertion is synchronised externally. The first write is accepted on the first posedge with rst_n high.

## Test plan

- Reset mid-run: write reg3 = 0xDEADBEEF and claim reg5, then pull rst_n low between edges → rd_data(3) = 0 and rd_busy(5) = 0 immediately, and both stay so after rst_n rises.
- Bypass: we0, wa0 = 7, wd0 = 0x11 with rd_addr0 = 7 in the same cycle → rd_data0 = 0x11 in that cycle (BYPASS=1). With BYPASS=0 it reads the old value, and 0x11 appears next cycle.
- Collision: we0/we1 both to reg 9, wd0 = 0xA, wd1 = 0xB → same-cycle read = 0xB; reg9 = 0xB after the edge.
- Scoreboard: claim reg 12 → rd_busy = 1 and busy_any = 1 next cycle. we1 to 12 with 0x55 → rd_busy = 0 and rd_data = 0x55 in the same cycle; busy_any = 0 after the edge. Claim and we1 to reg 12 in the same cycle → rd_busy = 1 next cycle.
- Zero register: we0/we1 to reg 0 with 0xFFFFFFFF and claim 0 → rd_data = 0 and rd_busy = 0 on all ports. With ZERO_R0=0, reg 0 holds 0xFFFFFFFF.
- Port independence (NRD=4, DATA_W=16, ADDR_W=3): load regs 1..7 with i·0x111, then read four distinct addresses per cycle across all 8 addresses → every lane matches, with no cross-lane bit leakage.
